// File: rtl/ws2812_rx_if.sv
// Receiver bus: raw WS2812 line in, decoded pixel/frame/error strobes out.
// Latency: none, signal bundle only.
// Backpressure: none, strobes are fire-and-forget and must be sampled when high.
interface ws2812_rx_if #(
  parameter int unsigned NUM_LEDS = 256
);
  localparam int IDX_W = $clog2(NUM_LEDS);

  logic              din_i;
  logic [23:0]       pix_o;
  logic              pix_valid_o;
  logic [IDX_W-1:0]  pix_idx_o;
  logic              frame_done_o;
  logic [IDX_W:0]    pix_cnt_o;
  logic              err_o;
  logic [1:0]        err_code_o;
  logic              busy_o;

  // Decoder side: consumes the line, drives results.
  modport master (
    input  din_i,
    output pix_o, pix_valid_o, pix_idx_o, frame_done_o, pix_cnt_o,
    output err_o, err_code_o, busy_o
  );

  // Driver/observer side: drives the line, watches results.
  modport slave (
    output din_i,
    input  pix_o, pix_valid_o, pix_idx_o, frame_done_o, pix_cnt_o,
    input  err_o, err_code_o, busy_o
  );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 pulse-width decoder: 24-bit pixels, frame index, latch-gap frame end.
// Latency: pix_valid_o 4 clk after the din_i falling edge of the last bit.
// Backpressure: none, every output is a one-cycle strobe with no stall.
module ws2812_rx #(
  parameter int unsigned SYSTEM_CLOCK  = 50000000,
  parameter int unsigned NUM_LEDS      = 256,
  parameter int unsigned T_MIN_NS      = 150,
  parameter int unsigned T_THRESH_NS   = 600,
  parameter int unsigned T_HIGH_MAX_NS = 1500,
  parameter int unsigned T_RESET_NS    = 50000
) (
  input  logic          clk_i,
  input  logic          reset_i,
  ws2812_rx_if.master   bus
);

  localparam int IDX_W = $clog2(NUM_LEDS);
  localparam int CNT_W = IDX_W + 1;

  // Nanosecond limits converted to whole clock cycles (truncated).
  localparam longint CYC_MIN   = (longint'(T_MIN_NS)      * longint'(SYSTEM_CLOCK)) / longint'(1000000000);
  localparam longint CYC_THR   = (longint'(T_THRESH_NS)   * longint'(SYSTEM_CLOCK)) / longint'(1000000000);
  localparam longint CYC_HMAX  = (longint'(T_HIGH_MAX_NS) * longint'(SYSTEM_CLOCK)) / longint'(1000000000);
  localparam longint CYC_RESET = (longint'(T_RESET_NS)    * longint'(SYSTEM_CLOCK)) / longint'(1000000000);

  localparam logic [16:0] MIN_LEN   = 17'(CYC_MIN);
  localparam logic [16:0] THR_LEN   = 17'(CYC_THR);
  localparam logic [16:0] HMAX_LEN  = 17'(CYC_HMAX);
  localparam logic [16:0] RESET_LEN = 17'(CYC_RESET);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_LEDS);

  typedef enum logic [1:0] {
    S_WAIT_GAP = 2'd0,
    S_IDLE     = 2'd1,
    S_HIGH     = 2'd2,
    S_LOW      = 2'd3
  } state_t;

  // Input conditioning
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic lvl_q, lvl_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic [15:0] dur_q, dur_d;
  logic [16:0] dur_len;

  // Decoder state
  state_t             state_q, state_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [22:0]        shift_q, shift_d;
  logic               ovf_q, ovf_d;
  logic [23:0]        new_word;
  logic               bit_one;

  // Registered outputs
  logic [23:0]        pix_q, pix_d;
  logic               pix_valid_q, pix_valid_d;
  logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   pix_cnt_out_q, pix_cnt_out_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               busy_q, busy_d;

  // Length of the current level including the cycle in progress; an edge
  // strobe cycle sees the finished length of the level that just ended.
  assign dur_len = {1'b0, dur_q} + 17'd1;
  assign bit_one = (dur_len >= THR_LEN);

  // Synchronizer, registered edge strobes aligned with lvl_q, and the
  // saturating duration counter that restarts on every edge.
  always_comb begin
    sync1_d = bus.din_i;
    sync2_d = sync1_q;
    lvl_d   = sync2_q;
    rise_d  = sync2_q & ~lvl_q;
    fall_d  = ~sync2_q & lvl_q;
    if (rise_q | fall_q) begin
      dur_d = '0;
    end else if (&dur_q) begin
      dur_d = dur_q;
    end else begin
      dur_d = dur_q + 16'd1;
    end
  end

  // Next-state and output decode for the frame FSM.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    shift_d       = shift_q;
    ovf_d         = ovf_q;
    pix_d         = pix_q;
    pix_valid_d   = 1'b0;
    pix_idx_d     = pix_idx_q;
    done_d        = 1'b0;
    pix_cnt_out_d = pix_cnt_out_q;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    busy_d        = busy_q;
    new_word      = {shift_q, bit_one};

    case (state_q)
      S_WAIT_GAP: begin
        // The fall cycle still carries the high length, so skip it.
        if (!lvl_q && !fall_q && (dur_len >= RESET_LEN)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      S_IDLE: begin
        if (rise_q) begin
          state_d = S_HIGH;
          busy_d  = 1'b1;
        end
      end

      S_HIGH: begin
        if (dur_len > HMAX_LEN) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          state_d    = S_WAIT_GAP;
          bit_cnt_d  = '0;
          pix_cnt_d  = '0;
          ovf_d      = 1'b0;
        end else if (fall_q) begin
          if (dur_len < MIN_LEN) begin
            err_d      = 1'b1;
            err_code_d = 2'd0;
            state_d    = S_WAIT_GAP;
            bit_cnt_d  = '0;
            pix_cnt_d  = '0;
            ovf_d      = 1'b0;
          end else begin
            state_d = S_LOW;
            shift_d = new_word[22:0];
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              if (pix_cnt_q == FULL_CNT) begin
                // Extra pixels are dropped; flag the overflow once per frame.
                if (!ovf_q) begin
                  err_d      = 1'b1;
                  err_code_d = 2'd3;
                  ovf_d      = 1'b1;
                end
              end else begin
                pix_d       = new_word;
                pix_valid_d = 1'b1;
                pix_idx_d   = pix_cnt_q[IDX_W-1:0];
                pix_cnt_d   = pix_cnt_q + CNT_W'(1);
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
      end

      S_LOW: begin
        if (rise_q) begin
          state_d = S_HIGH;
        end else if (dur_len >= RESET_LEN) begin
          done_d        = 1'b1;
          pix_cnt_out_d = pix_cnt_q;
          if (bit_cnt_q != 5'd0) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end
          bit_cnt_d = '0;
          pix_cnt_d = '0;
          ovf_d     = 1'b0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d = S_WAIT_GAP;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      lvl_q         <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      dur_q         <= '0;
      state_q       <= S_WAIT_GAP;
      bit_cnt_q     <= '0;
      pix_cnt_q     <= '0;
      shift_q       <= '0;
      ovf_q         <= 1'b0;
      pix_q         <= '0;
      pix_valid_q   <= 1'b0;
      pix_idx_q     <= '0;
      done_q        <= 1'b0;
      pix_cnt_out_q <= '0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      lvl_q         <= lvl_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      dur_q         <= dur_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      shift_q       <= shift_d;
      ovf_q         <= ovf_d;
      pix_q         <= pix_d;
      pix_valid_q   <= pix_valid_d;
      pix_idx_q     <= pix_idx_d;
      done_q        <= done_d;
      pix_cnt_out_q <= pix_cnt_out_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.pix_o        = pix_q;
  assign bus.pix_valid_o  = pix_valid_q;
  assign bus.pix_idx_o    = pix_idx_q;
  assign bus.frame_done_o = done_q;
  assign bus.pix_cnt_o    = pix_cnt_out_q;
  assign bus.err_o        = err_q;
  assign bus.err_code_o   = err_code_q;
  assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: a 256-pixel and a 4-pixel decoder share one line.
// Latency: expected strobes carry the exact cycle they must appear in.
// Backpressure: none, the monitor samples every strobe on the falling clock edge.
module tb_ws2812_rx;

  localparam int NUM_A = 256;
  localparam int NUM_B = 4;
  localparam int GAP   = 2700;

  typedef struct {
    int          cyc;
    logic [23:0] val;
    int          idx;
    int          code;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic din;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model state: bits of the current frame, whether the decoder
  // has seen a latch gap since the last reset/error, time of the last fall.
  bit   frame_bits[$];
  bit   armed;
  int   last_fall;

  exp_t pq0[$], pq1[$], eq0[$], eq1[$], dq0[$], dq1[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ws2812_rx_if #(.NUM_LEDS(NUM_A)) bus_a ();
  ws2812_rx_if #(.NUM_LEDS(NUM_B)) bus_b ();
  assign bus_a.din_i = din;
  assign bus_b.din_i = din;

  ws2812_rx #(.NUM_LEDS(NUM_A)) dut_a (.clk_i(clk), .reset_i(reset), .bus(bus_a));
  ws2812_rx #(.NUM_LEDS(NUM_B)) dut_b (.clk_i(clk), .reset_i(reset), .bus(bus_b));

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int d, input int kind, input exp_t e);
    case ({d[0], kind[1:0]})
      3'b000: pq0.push_back(e);
      3'b001: eq0.push_back(e);
      3'b010: dq0.push_back(e);
      3'b100: pq1.push_back(e);
      3'b101: eq1.push_back(e);
      default: dq1.push_back(e);
    endcase
  endtask

  // Pixel p (0-based) of a frame: delivered if it fits, one overflow error otherwise.
  task automatic expect_pixel(input int d, input int n, input int p, input logic [23:0] v, input int c);
    exp_t e;
    e.cyc = c; e.val = v; e.idx = p; e.code = 0;
    if (p < n) begin
      push(d, 0, e);
    end else if (p == n) begin
      e.code = 3;
      push(d, 1, e);
    end
  endtask

  task automatic expect_err(input int code, input int c);
    exp_t e;
    e.cyc = c; e.val = '0; e.idx = 0; e.code = code;
    push(0, 1, e);
    push(1, 1, e);
  endtask

  task automatic send_bit(input bit b, input int hi, input int lo);
    int f, p;
    logic [23:0] v;
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    f = cyc;
    last_fall = f;
    if (armed) begin
      frame_bits.push_back(b);
      if (frame_bits.size() % 24 == 0) begin
        p = frame_bits.size() / 24 - 1;
        v = '0;
        for (int j = 0; j < 24; j++) v[23-j] = frame_bits[p*24 + j];
        expect_pixel(0, NUM_A, p, v, f + 4);
        expect_pixel(1, NUM_B, p, v, f + 4);
      end
    end
    repeat (lo) @(negedge clk);
  endtask

  // mode 0: 400/800 ns highs, 1.25 us period; 1: random legal;
  // 2: 29/30 clk threshold edges; 3: 7/75 clk extremes; 4: fast.
  task automatic send_pixel(input logic [23:0] v, input int mode);
    int hi, lo;
    for (int j = 23; j >= 0; j--) begin
      case (mode)
        0: begin hi = v[j] ? 40 : 20; lo = 63 - hi; end
        1: begin
          hi = v[j] ? int'($urandom_range(75, 30)) : int'($urandom_range(29, 7));
          lo = int'($urandom_range(20, 5));
        end
        2: begin hi = v[j] ? 30 : 29; lo = 20; end
        3: begin hi = v[j] ? 75 : 7; lo = 20; end
        default: begin hi = v[j] ? 40 : 20; lo = 10; end
      endcase
      send_bit(v[j], hi, lo);
    end
  endtask

  task automatic send_bits(input int n);
    for (int j = 0; j < n; j++) send_bit(j[0], j[0] ? 40 : 20, 15);
  endtask

  // Line low for lo cycles; completes a frame (if one is open) and arms the model.
  task automatic gap(input int lo);
    int nb, np;
    exp_t e;
    if (armed && frame_bits.size() > 0) begin
      nb = frame_bits.size();
      np = nb / 24;
      e.cyc = last_fall + 2504; e.val = '0; e.code = 2;
      e.idx = (np < NUM_A) ? np : NUM_A;
      push(0, 2, e);
      e.idx = (np < NUM_B) ? np : NUM_B;
      push(1, 2, e);
      if (nb % 24 != 0) expect_err(2, last_fall + 2504);
    end
    frame_bits.delete();
    armed = 1'b1;
    din = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic glitch(input int hi);
    int f;
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    f = cyc;
    if (armed) expect_err(0, f + 4);
    armed = 1'b0;
    frame_bits.delete();
    repeat (20) @(negedge clk);
  endtask

  task automatic long_high(input int hold);
    din = 1'b1;
    if (armed) expect_err(1, cyc + 80);
    armed = 1'b0;
    frame_bits.delete();
    repeat (hold) @(negedge clk);
    din = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    armed = 1'b0;
    frame_bits.delete();
  endtask

  task automatic check_busy(input bit e);
    chk(bus_a.busy_o == e, "dut0_busy", longint'(bus_a.busy_o), longint'(e));
    chk(bus_b.busy_o == e, "dut1_busy", longint'(bus_b.busy_o), longint'(e));
  endtask

  task automatic mon(input int d, input logic pv, input logic [23:0] pix, input int idx,
                     input logic done, input int cnt, input logic err, input logic [1:0] code);
    exp_t e;
    bit have;
    if (pv) begin
      have = 1'b0;
      if (d == 0 && pq0.size() > 0) begin e = pq0.pop_front(); have = 1'b1; end
      else if (d == 1 && pq1.size() > 0) begin e = pq1.pop_front(); have = 1'b1; end
      chk(have, $sformatf("dut%0d_pix_strobe_expected", d), 1, 0);
      if (have) begin
        chk(pix == e.val, $sformatf("dut%0d_pix_value", d), longint'(pix), longint'(e.val));
        chk(idx == e.idx, $sformatf("dut%0d_pix_idx", d), idx, e.idx);
        chk(cyc == e.cyc, $sformatf("dut%0d_pix_cycle", d), cyc, e.cyc);
      end
    end
    if (err) begin
      have = 1'b0;
      if (d == 0 && eq0.size() > 0) begin e = eq0.pop_front(); have = 1'b1; end
      else if (d == 1 && eq1.size() > 0) begin e = eq1.pop_front(); have = 1'b1; end
      chk(have, $sformatf("dut%0d_err_strobe_expected", d), longint'(code), 0);
      if (have) begin
        chk(int'(code) == e.code, $sformatf("dut%0d_err_code", d), longint'(code), e.code);
        chk(cyc == e.cyc, $sformatf("dut%0d_err_cycle", d), cyc, e.cyc);
      end
    end
    if (done) begin
      have = 1'b0;
      if (d == 0 && dq0.size() > 0) begin e = dq0.pop_front(); have = 1'b1; end
      else if (d == 1 && dq1.size() > 0) begin e = dq1.pop_front(); have = 1'b1; end
      chk(have, $sformatf("dut%0d_done_strobe_expected", d), longint'(cnt), 0);
      if (have) begin
        chk(cnt == e.idx, $sformatf("dut%0d_done_cnt", d), cnt, e.idx);
        chk(cyc == e.cyc, $sformatf("dut%0d_done_cycle", d), cyc, e.cyc);
      end
    end
  endtask

  // Monitor: every strobe must match the head of its expected queue.
  always @(negedge clk) begin
    mon(0, bus_a.pix_valid_o, bus_a.pix_o, int'(bus_a.pix_idx_o), bus_a.frame_done_o,
        int'(bus_a.pix_cnt_o), bus_a.err_o, bus_a.err_code_o);
    mon(1, bus_b.pix_valid_o, bus_b.pix_o, int'(bus_b.pix_idx_o), bus_b.frame_done_o,
        int'(bus_b.pix_cnt_o), bus_b.err_o, bus_b.err_code_o);
  end

  initial begin
    din   = 1'b0;
    reset = 1'b1;
    armed = 1'b0;
    last_fall = 0;
    repeat (5) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    chk(bus_a.pix_o == 24'h0, "rst_pix", longint'(bus_a.pix_o), 0);
    chk(bus_a.pix_valid_o == 1'b0, "rst_pix_valid", longint'(bus_a.pix_valid_o), 0);
    chk(bus_a.pix_idx_o == '0, "rst_pix_idx", longint'(bus_a.pix_idx_o), 0);
    chk(bus_a.frame_done_o == 1'b0, "rst_done", longint'(bus_a.frame_done_o), 0);
    chk(bus_a.pix_cnt_o == '0, "rst_pix_cnt", longint'(bus_a.pix_cnt_o), 0);
    chk(bus_a.err_o == 1'b0, "rst_err", longint'(bus_a.err_o), 0);
    chk(bus_a.err_code_o == 2'd0, "rst_err_code", longint'(bus_a.err_code_o), 0);
    chk(bus_b.pix_o == 24'h0, "rst_pix_b", longint'(bus_b.pix_o), 0);
    check_busy(1'b0);

    gap(3000);

    // Nominal 3-pixel frame at 1.25 us bit period.
    send_pixel(24'hFF0000, 0);
    check_busy(1'b1);
    send_pixel(24'h00AA55, 0);
    send_pixel(24'h123456, 0);
    gap(3000);
    check_busy(1'b0);

    // Six pixels: overflows the 4-pixel decoder.
    for (int i = 0; i < 6; i++) send_pixel(24'($urandom), 4);
    gap(GAP);

    // Threshold and extreme legal pulse widths.
    send_pixel(24'h5A5A5A, 2);
    send_pixel(24'hC3C3C3, 3);
    gap(GAP);

    // Glitch mid-frame, then recovery after a gap.
    send_pixel(24'($urandom), 4);
    send_bits(6);
    glitch(6);
    gap(GAP);
    send_pixel(24'($urandom), 0);
    gap(GAP);

    // High held too long.
    long_high(100);
    gap(GAP);

    // Partial pixel at the gap.
    send_bits(10);
    gap(GAP);

    // Line high at reset exit, frame without a prior gap is ignored.
    din = 1'b1;
    do_reset(5);
    repeat (200) @(negedge clk);
    din = 1'b0;
    repeat (20) @(negedge clk);
    send_pixel(24'hABCDEF, 4);
    send_pixel(24'h13579B, 4);
    gap(GAP);
    send_pixel(24'($urandom), 4);
    gap(GAP);

    // Reset mid-frame after bit 12 of pixel 1.
    send_pixel(24'($urandom), 4);
    send_bits(12);
    repeat (5) @(negedge clk);
    do_reset(2);
    gap(GAP);
    send_pixel(24'($urandom), 4);
    gap(GAP);

    // Random frames with random legal timing.
    for (int f = 0; f < 3; f++) begin
      int np;
      np = int'($urandom_range(5, 1));
      for (int i = 0; i < np; i++) send_pixel(24'($urandom), 1);
      gap(GAP);
    end

    repeat (100) @(negedge clk);
    chk(pq0.size() == 0, "dut0_pix_pending", pq0.size(), 0);
    chk(pq1.size() == 0, "dut1_pix_pending", pq1.size(), 0);
    chk(eq0.size() == 0, "dut0_err_pending", eq0.size(), 0);
    chk(eq1.size() == 0, "dut1_err_pending", eq1.size(), 0);
    chk(dq0.size() == 0, "dut0_done_pending", dq0.size(), 0);
    chk(dq1.size() == 0, "dut1_done_pending", dq1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Receive side of the WS2812 single-wire pixel protocol driven by our strip controllers' DO outputs.
- Decodes the pulse-width bitstream into 24-bit pixel words, indexes them within a frame, and signals frame end on the latch/reset gap.
- Used on spare GPIO inputs for on-board loopback checking of the DO outputs, and as the decode front end of a future strip-repeater design.

Parameters:
- SYSTEM_CLOCK, 50000000, clk_i frequency in Hz.
- NUM_LEDS, 256, pixels accepted per frame; pix_idx_o width is clog2(NUM_LEDS).
- T_MIN_NS, 150, high pulses shorter than this are glitches.
- T_THRESH_NS, 600, high time at or above this decodes as 1, below as 0.
- T_HIGH_MAX_NS, 1500, high time above this is an error.
- T_RESET_NS, 50000, low time at or above this is the latch gap.
- Cycle counts are computed as ns*SYSTEM_CLOCK/1e9, truncated. At 50 MHz: MIN=7, THRESH=30, HMAX=75, RESET=2500.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- din_i  in  1  asynchronous WS2812 bitstream.
- pix_o  out  24  last decoded pixel, first-received bit in bit 23, wire order unchanged (GRB).
- pix_valid_o  out  1  one-cycle strobe, pix_o/pix_idx_o valid.
- pix_idx_o  out  clog2(NUM_LEDS)  index of pixel in frame, 0-based.
- frame_done_o  out  1  one-cycle strobe on latch gap after a non-empty frame.
- pix_cnt_o  out  clog2(NUM_LEDS)+1  pixels delivered in frame; valid with frame_done_o.
- err_o  out  1  one-cycle error strobe.
- err_code_o  out  2  0 glitch, 1 high too long, 2 partial pixel at gap, 3 overflow (>NUM_LEDS pixels); valid with err_o.
- busy_o  out  1  high from first rising edge of a frame until frame_done_o or the gap.

Behaviour:
Input conditioning:
- din_i passes through a 2-flop synchronizer, then a previous-value register for edge detect.
- All timing is measured on the synchronized signal.

Counters:
- One 16-bit duration counter, cleared on every synchronized edge, saturating at all ones.
- bit_cnt: 0..23.
- pix_cnt: 0..NUM_LEDS.

Reset:
- All outputs 0, pix_o 0, counters 0, state WAIT_GAP.
- Reset mid-frame discards all partial data; no strobes fire.

States:
- WAIT_GAP: wait for low time >= RESET cycles, then go to IDLE. A rising edge restarts the wait. Entered from reset and after any error.
- IDLE: rising edge -> HIGH, busy_o=1.
- HIGH (counting high time):
  - Falling edge with count < MIN: err code 0 -> WAIT_GAP.
  - Count exceeds HMAX while still high: err code 1 immediately -> WAIT_GAP.
  - Otherwise shift in bit (count >= THRESH gives 1) -> LOW.
- LOW:
  - Rising edge -> HIGH.
  - Low count reaches RESET -> gap handling.
  - Any low time shorter than RESET between bits is legal.

Pixel completion:
- On the 24th bit: pix_o loads, pix_valid_o=1, pix_idx_o=pix_cnt, pix_cnt increments, bit_cnt returns to 0.
- Latency: pix_valid_o asserts exactly 4 clk after the din_i falling edge of bit 23 (2 sync, 1 edge, 1 output register).

Overflow:
- The pixel completing while pix_cnt == NUM_LEDS is not delivered and pix_valid_o does not fire.
- err code 3 fires once per frame; decoding continues to the gap.

Gap handling (low count reaches RESET while in LOW):
- If bit_cnt != 0: err code 2. frame_done_o still fires, with pix_cnt_o counting whole pixels only.
- frame_done_o=1 and busy_o=0 in the same cycle. Counters clear; next state is IDLE.
- Gaps from IDLE with no bits produce no strobes.

Simultaneous events:
- pix_valid_o and err_o may assert in the same cycle.
- frame_done_o can never coincide with pix_valid_o, because a gap needs >= RESET cycles after the last edge.
- err_code_o holds its value until the next err_o.

Test Plan:
- Reset, din_i low 60 us, then 3 pixels 0xFF0000, 0x00AA55, 0x123456 (T0H 400 ns, T1H 800 ns, period 1.25 us), then 60 us low -> pix_valid_o x3 with idx 0,1,2 and exact values, each 4 clk after the falling edge of bit 23. One frame_done_o with pix_cnt_o=3; no err_o.
- din_i high at reset exit, then a frame without a prior 50 us gap -> no pix_valid_o until WAIT_GAP completes. The following frame decodes correctly.
- Boundary: high pulses of 29 clk and 30 clk -> bits 0 and 1. A 6-clk pulse -> err_o code 0, then recovery on the next gap+frame. A 76-clk held high -> err_o code 1 at cycle 76.
- 10 bits then 60 us low -> err_o code 2 and frame_done_o with pix_cnt_o=0; pix_valid_o never fires.
- NUM_LEDS=4 build, 6 pixels sent -> 4 pix_valid_o (idx 0..3), one err_o code 3, frame_done_o with pix_cnt_o=4.
- reset_i pulsed after bit 12 of pixel 1 -> no strobes. After a 50 us gap a new frame starts at idx 0.
